// File: rtl/cp0_register_file.sv
// cp0_register_file -- MIPS-style coprocessor-0 register file.
//
// Holds Count, Compare, Status, Cause, EPC, PRId and Config. It has one write
// port (driven from writeback) and one combinational read port (driven from
// execute). The live register values are also exported directly.
//
// Optional feature: define CP0_TIMER_EN to build the Count/Compare timer.
// Without it, Count and Compare read as 0, writes to them are dropped and
// timer_interrupt_output is tied low.
//
// Ports:
//   clock                  rising-edge clock
//   reset                  asynchronous, active-high reset
//   write_enable_input     CP0 write strobe (registered, from MEM/WB)
//   write_address_input    CP0 register number to write
//   write_data_input       CP0 write data
//   read_address_input     CP0 register number to read
//   interrupt_input        external hardware interrupt lines, sampled into Cause[15:10]
//   data_output            read data (pre-write value, 0 for unmapped numbers)
//   count_output .. prid_output  live register values
//   timer_interrupt_output sticky Count==Compare flag
module cp0_register_file #(
  parameter logic [31:0] PRID_VALUE = 32'h004C0102
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable_input,
  input  logic [4:0]  write_address_input,
  input  logic [31:0] write_data_input,
  input  logic [4:0]  read_address_input,
  input  logic [5:0]  interrupt_input,
  output logic [31:0] data_output,
  output logic [31:0] count_output,
  output logic [31:0] compare_output,
  output logic [31:0] status_output,
  output logic [31:0] cause_output,
  output logic [31:0] epc_output,
  output logic [31:0] config_output,
  output logic [31:0] prid_output,
  output logic        timer_interrupt_output
);

  localparam logic [4:0]  ADDR_COUNT   = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE = 5'd11;
  localparam logic [4:0]  ADDR_STATUS  = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
  localparam logic [4:0]  ADDR_EPC     = 5'd14;
  localparam logic [4:0]  ADDR_PRID    = 5'd15;
  localparam logic [4:0]  ADDR_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RESET = 32'h10000000;
  localparam logic [31:0] CONFIG_VALUE = 32'h00008000;

  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;

  logic [31:0] status_q;
  logic [31:0] epc_q;
  // Only the Cause bits that carry state are stored; the rest are wired to 0.
  logic        cause_iv;
  logic        cause_wp;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;

  assign wr_status = write_enable_input && (write_address_input == ADDR_STATUS);
  assign wr_cause  = write_enable_input && (write_address_input == ADDR_CAUSE);
  assign wr_epc    = write_enable_input && (write_address_input == ADDR_EPC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q    <= STATUS_RESET;
      epc_q       <= '0;
      cause_iv    <= 1'b0;
      cause_wp    <= 1'b0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
    end else begin
      if (wr_status) status_q <= write_data_input;
      if (wr_epc)    epc_q    <= write_data_input;
      if (wr_cause) begin
        cause_iv    <= write_data_input[23];
        cause_wp    <= write_data_input[22];
        cause_ip_sw <= write_data_input[9:8];
      end
      // Hardware interrupt pending bits track the pins every cycle,
      // independent of any software write to Cause.
      cause_ip_hw <= interrupt_input;
    end
  end

`ifdef CP0_TIMER_EN
  logic        wr_count;
  logic        wr_compare;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_q;

  assign wr_count   = write_enable_input && (write_address_input == ADDR_COUNT);
  assign wr_compare = write_enable_input && (write_address_input == ADDR_COMPARE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      // A software load of Count replaces this cycle's increment.
      count_q <= wr_count ? write_data_input : count_q + 32'd1;
      if (wr_compare) compare_q <= write_data_input;
      // Compare write acknowledges the interrupt and takes priority over a
      // match seen in the same cycle. Compare==0 disables matching.
      if (wr_compare) begin
        timer_q <= 1'b0;
      end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
        timer_q <= 1'b1;
      end
    end
  end

  assign count_output           = count_q;
  assign compare_output         = compare_q;
  assign timer_interrupt_output = timer_q;
`else
  assign count_output           = '0;
  assign compare_output         = '0;
  assign timer_interrupt_output = 1'b0;
`endif

  assign status_output = status_q;
  assign epc_output    = epc_q;
  assign cause_output  = {8'h00, cause_iv, cause_wp, 6'b000000,
                          cause_ip_hw, cause_ip_sw, 8'h00};
  assign config_output = CONFIG_VALUE;
  assign prid_output   = PRID_VALUE;

  // Read port shows current register contents only; a write in the same
  // cycle becomes visible after the edge.
  always_comb begin
    data_output = '0;
    case (read_address_input)
      ADDR_COUNT:   data_output = count_output;
      ADDR_COMPARE: data_output = compare_output;
      ADDR_STATUS:  data_output = status_output;
      ADDR_CAUSE:   data_output = cause_output;
      ADDR_EPC:     data_output = epc_output;
      ADDR_PRID:    data_output = prid_output;
      ADDR_CONFIG:  data_output = config_output;
      default:      data_output = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_register_file.sv
// Self-checking bench for cp0_register_file. Works in both builds
// (with or without CP0_TIMER_EN); timer expectations follow the build.
module tb_cp0_register_file;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif
  localparam logic [31:0] PRID = 32'h004C0102;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra;
  logic [5:0]  irq;
  logic [31:0] data_output, count_output, compare_output, status_output;
  logic [31:0] cause_output, epc_output, config_output, prid_output;
  logic        timer_interrupt_output;

  always #5 clock = ~clock;

  cp0_register_file #(.PRID_VALUE(PRID)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .write_enable_input     (we),
    .write_address_input    (wa),
    .write_data_input       (wd),
    .read_address_input     (ra),
    .interrupt_input        (irq),
    .data_output            (data_output),
    .count_output           (count_output),
    .compare_output         (compare_output),
    .status_output          (status_output),
    .cause_output           (cause_output),
    .epc_output             (epc_output),
    .config_output          (config_output),
    .prid_output            (prid_output),
    .timer_interrupt_output (timer_interrupt_output)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: a handful of named values updated once per edge.
  logic [31:0] m_count, m_compare, m_status, m_epc, m_cause_sw;
  logic [5:0]  m_irq;
  logic        m_timer;

  task automatic model_reset();
    m_count    = 32'h0;
    m_compare  = 32'h0;
    m_status   = 32'h10000000;
    m_epc      = 32'h0;
    m_cause_sw = 32'h0;
    m_irq      = 6'h0;
    m_timer    = 1'b0;
  endtask

  function automatic logic [31:0] m_cause();
    return m_cause_sw | (32'(m_irq) << 10);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return 32'h00008000;
      default: return 32'h0;
    endcase
  endfunction

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] c;
    logic [31:0] k;
    logic        t;
    c = m_count;
    k = m_compare;
    t = m_timer;
    if (TIMER_ON) begin
      if (m_compare != 0 && m_count == m_compare) t = 1'b1;
      if (we && wa == 5'd11) begin
        t = 1'b0;
        k = wd;
      end
      c = (we && wa == 5'd9) ? wd : m_count + 32'd1;
    end
    if (we && wa == 5'd12) m_status = wd;
    if (we && wa == 5'd14) m_epc = wd;
    if (we && wa == 5'd13) m_cause_sw = wd & 32'h00C00300;
    m_irq     = irq;
    m_count   = c;
    m_compare = k;
    m_timer   = t;
  endtask

  task automatic check_all();
    check("data_output",    data_output,    m_read(ra));
    check("timer_irq",      32'(timer_interrupt_output), 32'(m_timer));
    check("count_output",   count_output,   m_count);
    check("compare_output", compare_output, m_compare);
    check("status_output",  status_output,  m_status);
    check("cause_output",   cause_output,   m_cause());
    check("epc_output",     epc_output,     m_epc);
    check("config_output",  config_output,  32'h00008000);
    check("prid_output",    prid_output,    PRID);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: drive at the falling edge, check pre-edge state, then advance
  // the model at the rising edge.
  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r, input logic [5:0] i);
    @(negedge clock);
    we = w; wa = a; wd = d; ra = r; irq = i;
    #1;
    check_all();
    @(posedge clock);
    model_edge();
  endtask

  // Read a register just after the rising edge, before the next falling edge.
  task automatic peek(input logic [4:0] r, output logic [31:0] v);
    #2;
    we = 1'b0;
    ra = r;
    #1;
    v = data_output;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] v;
    logic [4:0]  a;
    logic [31:0] d;

    tbl[0] = '{5'd12, 32'hDEADBEEF, 5'd12, 32'hDEADBEEF};
    tbl[1] = '{5'd14, 32'h12345678, 5'd14, 32'h12345678};
    tbl[2] = '{5'd13, 32'hFFFFFFFF, 5'd13, 32'h00C00300};
    tbl[3] = '{5'd13, 32'h00000100, 5'd13, 32'h00000100};
    tbl[4] = '{5'd16, 32'h00000000, 5'd16, 32'h00008000};
    tbl[5] = '{5'd15, 32'h00000000, 5'd15, 32'h004C0102};
    tbl[6] = '{5'd20, 32'h0000FFFF, 5'd20, 32'h00000000};
    tbl[7] = '{5'd0,  32'h00000001, 5'd0,  32'h00000000};
    tbl[8] = '{5'd12, 32'h00000000, 5'd12, 32'h00000000};
    tbl[9] = '{5'd31, 32'hA5A5A5A5, 5'd31, 32'h00000000};

    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = 5'd12; irq = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    check_all();

    // Release shortly after a rising edge so the next edge is the first count.
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (5) step(1'b0, 5'd0, 32'h0, 5'd9, 6'h0);
    peek(5'd9, v);  check("count_after_5", v, TIMER_ON ? 32'd5 : 32'd0);
    peek(5'd12, v); check("status_reset", v, 32'h10000000);
    peek(5'd15, v); check("prid_reset", v, 32'h004C0102);
    peek(5'd16, v); check("config_reset", v, 32'h00008000);

    // Count wrap.
    step(1'b1, 5'd9, 32'hFFFFFFFE, 5'd9, 6'h0);
    exp_q.push_back(TIMER_ON ? 32'hFFFFFFFE : 32'h0);
    exp_q.push_back(TIMER_ON ? 32'hFFFFFFFF : 32'h0);
    exp_q.push_back(32'h00000000);
    while (exp_q.size() > 0) begin
      peek(5'd9, v);
      check("count_wrap", v, exp_q.pop_front());
      step(1'b0, 5'd0, 32'h0, 5'd9, 6'h0);
    end

    // Timer match at Count==20, sticky, then cleared by Compare=0.
    step(1'b1, 5'd9, 32'd10, 5'd9, 6'h0);
    step(1'b1, 5'd11, 32'd20, 5'd11, 6'h0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 5'd0, 32'h0, 5'd9, 6'h0);
      peek(5'd9, v);
      // The flag is set on the edge whose pre-edge Count was 20.
      check("timer_rise", 32'(timer_interrupt_output), 32'(TIMER_ON && v >= 32'd21));
    end
    step(1'b1, 5'd11, 32'd0, 5'd11, 6'h0);
    peek(5'd11, v);
    check("timer_clear", 32'(timer_interrupt_output), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 5'd0, 32'h0, 5'd9, 6'h0);
      check("timer_stay_clear", 32'(timer_interrupt_output), 32'h0);
    end

    // Cause write mask plus sampled interrupt lines:
    // IV|WP = 0x00C00000, 6'b101010 << 10 = 0xA800, IP1:0 = 0x300.
    step(1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 6'b101010);
    peek(5'd13, v); check("cause_write", v, 32'h00C0AB00);
    step(1'b0, 5'd0, 32'h0, 5'd13, 6'b000000);
    peek(5'd13, v); check("cause_irq_drop", v, 32'h00C00300);

    // Table of write-then-read vectors.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, tbl[k].wa, tbl[k].wd, tbl[k].ra, 6'h0);
      peek(tbl[k].ra, v);
      check($sformatf("tbl_%0d", k), v, tbl[k].exp);
    end

    // Reset during a pending Compare match.
    step(1'b1, 5'd11, 32'd50, 5'd11, 6'h0);
    step(1'b1, 5'd9, 32'd50, 5'd9, 6'h0);
    #2;
    we = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clock); #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 5'd0, 32'h0, 5'd9, 6'h0);
      check("timer_after_reset", 32'(timer_interrupt_output), 32'h0);
    end
    peek(5'd9, v); check("count_restart", v, TIMER_ON ? 32'd3 : 32'd0);

    // Count=7, Compare=1, then 50 idle cycles: no interrupt either build.
    step(1'b1, 5'd9, 32'd7, 5'd9, 6'h0);
    step(1'b1, 5'd11, 32'd1, 5'd11, 6'h0);
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 5'd0, 32'h0, (k % 2 == 0) ? 5'd9 : 5'd11, 6'h0);
      check("timer_idle", 32'(timer_interrupt_output), 32'h0);
    end
    peek(5'd11, v); check("compare_idle", v, TIMER_ON ? 32'd1 : 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0: a = 5'd9;
        1: a = 5'd11;
        2: a = 5'd12;
        3: a = 5'd13;
        4: a = 5'd14;
        5: a = 5'd15;
        6: a = 5'd16;
        default: a = 5'($urandom_range(0, 31));
      endcase
      d = $urandom;
      // Often aim Compare just ahead of Count so matches actually occur.
      if (a == 5'd11 && $urandom_range(0, 1) == 1) d = m_count + 32'($urandom_range(1, 4));
      step(1'($urandom_range(0, 1)), a, d, 5'($urandom_range(0, 31)),
           6'($urandom_range(0, 63)));
    end
    @(negedge clock);
    we = 1'b0;
    #1;
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
